ifu_fetch: RTL and testbench

Instruction fetch unit for the NPC RV64 core, sitting directly upstream of the decode/control stage. It owns the architectural PC and issues one instruction-memory request per instruction over a valid/ready handshake. It latches the returned 32-bit word and presents it to decode. In the commit cycle it pulses `inst_update`, then selects the next PC from decode's `sel_nextpc` and the execute-stage target buses.

---
 rtl/ifu_fetch.sv | 105 ++++++++++
 tb/tb_ifu_fetch.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word per instruction over valid/ready,
// and commits the next PC. Optional misaligned-PC trap to HALT under IFU_MISALIGN_CHK_EN.
module ifu_fetch #(
    parameter int                XLEN     = 64,
    parameter logic [XLEN-1:0]   RESET_PC = 'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc,
    output logic            inst_update,
    input  logic            ex_busy,
    input  logic [1:0]      sel_nextpc,
    input  logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic [XLEN-1:0] trap_target,
    output logic            fetch_err
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_EXEC
`ifdef IFU_MISALIGN_CHK_EN
        , S_HALT
`endif
    } state_t;

    state_t          state;
    logic [XLEN-1:0] next_pc;
    logic            commit;

    always_comb begin
        next_pc = pc + XLEN'(4);
        unique case (sel_nextpc)
            2'b00: next_pc = pc + XLEN'(4);
            2'b01: next_pc = br_target;
            2'b10: next_pc = jalr_target & ~XLEN'(1);
            2'b11: next_pc = trap_target;
            default: next_pc = pc + XLEN'(4);
        endcase
    end

    // Handshake outputs are masked by rst so nothing leaks out during a reset cycle.
    assign commit         = (state == S_EXEC) && !ex_busy;
    assign inst_update    = commit && !rst;
    assign imem_req_valid = (state == S_REQ) && !rst;
    assign imem_addr      = pc;

`ifdef IFU_MISALIGN_CHK_EN
    logic fetch_err_q;
    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
            pc    <= RESET_PC;
            inst  <= 32'h0000_0013;
`ifdef IFU_MISALIGN_CHK_EN
            fetch_err_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req_ready) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        inst  <= imem_rsp_data;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!ex_busy) begin
                        pc <= next_pc;
`ifdef IFU_MISALIGN_CHK_EN
                        // The faulty PC is kept in pc so a debugger can see where it went.
                        if (next_pc[1:0] != 2'b00) begin
                            fetch_err_q <= 1'b1;
                            state       <= S_HALT;
                        end else begin
                            state <= S_REQ;
                        end
`else
                        state <= S_REQ;
`endif
                    end
                end
`ifdef IFU_MISALIGN_CHK_EN
                S_HALT: state <= S_HALT;
`endif
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch; the misalign test adapts to IFU_MISALIGN_CHK_EN.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        inst_update;
    logic        ex_busy;
    logic [1:0]  sel_nextpc;
    logic [63:0] br_target;
    logic [63:0] jalr_target;
    logic [63:0] trap_target;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst           (inst),
        .pc             (pc),
        .inst_update    (inst_update),
        .ex_busy        (ex_busy),
        .sel_nextpc     (sel_nextpc),
        .br_target      (br_target),
        .jalr_target    (jalr_target),
        .trap_target    (trap_target),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Takes the DUT from REQ to EXEC with a one-cycle response; leaves commit inputs to the caller.
    task automatic fetch_to_exec(input logic [31:0] word);
        imem_req_ready = 1'b1;
        cycle();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word;
        cycle();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        ex_busy = 1'b0; sel_nextpc = 2'b00;
        br_target = 64'h0; jalr_target = 64'h0; trap_target = 64'h0;
        cycle();
        cycle();
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", imem_req_valid); end
        checks++; if (inst_update !== 1'b0) begin failures++; $display("[TB] FAIL reset_update got=%b exp=0", inst_update); end
        checks++; if (pc !== 64'h8000_0000) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=%h", pc, 64'h8000_0000); end
        checks++; if (inst !== 32'h0000_0013) begin failures++; $display("[TB] FAIL reset_inst got=%h exp=00000013", inst); end
        checks++; if (fetch_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", fetch_err); end
        imem_req_ready = 1'b0;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_basic();
        imem_req_ready = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL basic_req_valid got=%b exp=1", imem_req_valid); end
        checks++; if (imem_addr !== 64'h8000_0000) begin failures++; $display("[TB] FAIL basic_req_addr got=%h exp=%h", imem_addr, 64'h8000_0000); end
        cycle();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0093;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_wait_valid got=%b exp=0", imem_req_valid); end
        cycle();
        imem_rsp_valid = 1'b0; ex_busy = 1'b0; sel_nextpc = 2'b00;
        #1;
        checks++; if (inst !== 32'h0000_0093) begin failures++; $display("[TB] FAIL basic_inst got=%h exp=00000093", inst); end
        checks++; if (inst_update !== 1'b1) begin failures++; $display("[TB] FAIL basic_update got=%b exp=1", inst_update); end
        cycle();
        checks++; if (pc !== 64'h8000_0004) begin failures++; $display("[TB] FAIL basic_pc got=%h exp=%h", pc, 64'h8000_0004); end
        checks++; if (inst_update !== 1'b0) begin failures++; $display("[TB] FAIL basic_update_drop got=%b exp=0", inst_update); end
    endtask

    task automatic test_stall();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imem_rsp_valid = 1'b1; imem_rsp_data = 32'hdead_beef;
            #1;
            checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid[%0d] got=%b exp=1", i, imem_req_valid); end
            checks++; if (imem_addr !== 64'h8000_0004) begin failures++; $display("[TB] FAIL stall_addr[%0d] got=%h exp=%h", i, imem_addr, 64'h8000_0004); end
            cycle();
        end
        imem_rsp_valid = 1'b0;
        checks++; if (inst !== 32'h0000_0093) begin failures++; $display("[TB] FAIL stall_rsp_ignored got=%h exp=00000093", inst); end
        imem_req_ready = 1'b1;
        cycle();
        imem_req_ready = 1'b0;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL stall_wait_entered got=%b exp=0", imem_req_valid); end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0113;
        cycle();
        imem_rsp_valid = 1'b0; sel_nextpc = 2'b00; ex_busy = 1'b0;
        checks++; if (inst !== 32'h0000_0113) begin failures++; $display("[TB] FAIL stall_inst got=%h exp=00000113", inst); end
        cycle();
        checks++; if (pc !== 64'h8000_0008) begin failures++; $display("[TB] FAIL stall_pc got=%h exp=%h", pc, 64'h8000_0008); end
    endtask

    task automatic test_busy();
        int pulses;
        pulses = 0;
        fetch_to_exec(32'h0020_8093);
        ex_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
            #1;
            checks++; if (inst_update !== 1'b0) begin failures++; $display("[TB] FAIL busy_update[%0d] got=%b exp=0", i, inst_update); end
            cycle();
        end
        imem_rsp_valid = 1'b0;
        checks++; if (inst !== 32'h0020_8093) begin failures++; $display("[TB] FAIL busy_inst_frozen got=%h exp=00208093", inst); end
        checks++; if (pc !== 64'h8000_0008) begin failures++; $display("[TB] FAIL busy_pc_frozen got=%h exp=%h", pc, 64'h8000_0008); end
        ex_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (inst_update === 1'b1) pulses++;
            cycle();
            ex_busy = 1'b1;
        end
        ex_busy = 1'b0;
        checks++; if (pulses !== 1) begin failures++; $display("[TB] FAIL busy_pulse_count got=%0d exp=1", pulses); end
        checks++; if (pc !== 64'h8000_000c) begin failures++; $display("[TB] FAIL busy_pc_once got=%h exp=%h", pc, 64'h8000_000c); end
    endtask

    task automatic test_routing();
        logic [1:0]  sels [5];
        logic [63:0] exps [5];
        sels = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        exps = '{64'h8000_0010, 64'h8000_0100, 64'h8000_0200, 64'h8000_0800, 64'h8000_0804};
        br_target = 64'h8000_0100; jalr_target = 64'h8000_0201; trap_target = 64'h8000_0800;
        for (int i = 0; i < 5; i++) begin
            sel_nextpc = ~sels[i];
            fetch_to_exec(32'h0000_0013);
            sel_nextpc = sels[i];
            cycle();
            sel_nextpc = 2'b00;
            checks++; if (imem_addr !== exps[i]) begin failures++; $display("[TB] FAIL route[%0d] sel=%b got=%h exp=%h", i, sels[i], imem_addr, exps[i]); end
        end
    endtask

    task automatic test_wrap();
        trap_target = 64'hffff_ffff_ffff_fffc;
        fetch_to_exec(32'h0000_0013);
        sel_nextpc = 2'b11;
        cycle();
        fetch_to_exec(32'h0000_0013);
        sel_nextpc = 2'b00;
        cycle();
        checks++; if (imem_addr !== 64'h0) begin failures++; $display("[TB] FAIL wrap_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_reset_mid();
        imem_req_ready = 1'b1;
        cycle();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_valid got=%b exp=0", imem_req_valid); end
        cycle();
        rst = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hcafe_f00d;
        #1;
        checks++; if (imem_addr !== 64'h8000_0000) begin failures++; $display("[TB] FAIL rstmid_pc got=%h exp=%h", imem_addr, 64'h8000_0000); end
        checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_req got=%b exp=1", imem_req_valid); end
        cycle();
        imem_rsp_valid = 1'b0;
        checks++; if (inst !== 32'h0000_0013) begin failures++; $display("[TB] FAIL rstmid_inst got=%h exp=00000013", inst); end
        checks++; if (inst_update !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_update got=%b exp=0", inst_update); end
    endtask

    task automatic test_misalign();
        int bad_valid;
        int bad_update;
        bad_valid = 0; bad_update = 0;
        br_target = 64'h8000_0102;
        fetch_to_exec(32'h0000_0013);
        sel_nextpc = 2'b01;
        #1;
        checks++; if (inst_update !== 1'b1) begin failures++; $display("[TB] FAIL mis_update got=%b exp=1", inst_update); end
        cycle();
        sel_nextpc = 2'b00;
        checks++; if (pc !== 64'h8000_0102) begin failures++; $display("[TB] FAIL mis_pc got=%h exp=%h", pc, 64'h8000_0102); end
`ifdef IFU_MISALIGN_CHK_EN
        checks++; if (fetch_err !== 1'b1) begin failures++; $display("[TB] FAIL mis_err got=%b exp=1", fetch_err); end
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (imem_req_valid !== 1'b0) bad_valid++;
            if (inst_update !== 1'b0) bad_update++;
            cycle();
        end
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        checks++; if (bad_valid !== 0) begin failures++; $display("[TB] FAIL halt_valid cycles_high=%0d exp=0", bad_valid); end
        checks++; if (bad_update !== 0) begin failures++; $display("[TB] FAIL halt_update cycles_high=%0d exp=0", bad_update); end
`else
        checks++; if (fetch_err !== 1'b0) begin failures++; $display("[TB] FAIL mis_err got=%b exp=0", fetch_err); end
        checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL mis_req got=%b exp=1", imem_req_valid); end
        checks++; if (imem_addr !== 64'h8000_0102) begin failures++; $display("[TB] FAIL mis_addr got=%h exp=%h", imem_addr, 64'h8000_0102); end
        checks++; if ((bad_valid + bad_update) !== 0) begin failures++; $display("[TB] FAIL mis_counters got=%0d exp=0", bad_valid + bad_update); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_busy();
        test_routing();
        test_wrap();
        test_reset_mid();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
